// File: rtl/rv32_pkg.sv
// rv32_pkg: shared state, PC-select and trap-cause encodings for the multi-cycle core.
package rv32_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        TRAP    = 3'd6
    } seq_state_t;
    localparam logic [1:0] PC_PLUS4       = 2'b00;
    localparam logic [1:0] PC_BRANCH      = 2'b01;
    localparam logic [1:0] PC_JUMP        = 2'b10;
    localparam logic [1:0] TRAP_NONE      = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL   = 2'b01;
    localparam logic [1:0] TRAP_IFETCH_TO = 2'b10;
    localparam logic [1:0] TRAP_DATA_TO   = 2'b11;
endpackage

// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: decoded controls, memory handshake and datapath strobes of the sequencer.
interface multicycle_sequencer_if;
    logic       run, clear_trap, reg_write, mem_read, mem_write, branch, jump, illegal;
    logic       branch_taken, mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, retired, trap;
    logic [1:0] pc_sel, trap_cause;
    logic [2:0] state_o;
    modport master (
        input  run, clear_trap, reg_write, mem_read, mem_write, branch, jump, illegal,
               branch_taken, mem_ready,
        output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, retired, trap,
               pc_sel, trap_cause, state_o
    );
    modport slave (
        output run, clear_trap, reg_write, mem_read, mem_write, branch, jump, illegal,
               branch_taken, mem_ready,
        input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, retired, trap,
               pc_sel, trap_cause, state_o
    );
endinterface

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts unanswered memory-request cycles and flags expiry; MEM_TIMEOUT=0 never expires.
module mem_timeout_ctr #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    input  logic ready,
    output logic expired
);
    localparam int W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);
    logic [W-1:0] cnt_q;
    // ready in the limit cycle suppresses expiry
    assign expired = (MEM_TIMEOUT != 0) && count_en && !ready && cnt_q == LIMIT;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else if (clear) cnt_q <= '0;
        else if (count_en && !ready && MEM_TIMEOUT != 0) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/execute/memory/writeback control FSM owning the shared memory port.
module multicycle_sequencer
    import rv32_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    multicycle_sequencer_if.master bus
);
    seq_state_t state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       trap_q, expired, mem_op, br_ret, st_ret;
    seq_state_t nxt;
    assign mem_op = bus.mem_read || bus.mem_write;
    assign nxt    = bus.run ? FETCH : IDLE;
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE:    state_d = nxt;
            FETCH:   if (bus.mem_ready) state_d = DECODE;
                     else if (expired) begin state_d = TRAP; cause_d = TRAP_IFETCH_TO; end
            DECODE:  if (bus.illegal) begin state_d = TRAP; cause_d = TRAP_ILLEGAL; end
                     else state_d = EXECUTE;
            EXECUTE: state_d = mem_op ? MEM : bus.branch ? nxt : WB;
            MEM:     if (bus.mem_ready) state_d = bus.mem_read ? WB : nxt;
                     else if (expired) begin state_d = TRAP; cause_d = TRAP_DATA_TO; end
            WB:      state_d = nxt;
            TRAP:    if (bus.clear_trap) begin state_d = IDLE; cause_d = TRAP_NONE; end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= TRAP_NONE;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            trap_q  <= state_d == TRAP && state_q != TRAP;
        end
    // a store can go straight from MEM to FETCH, so clear on any entry, not just from idle states
    mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_to (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    ((state_d == FETCH || state_d == MEM) && state_d != state_q),
        .count_en (bus.mem_req),
        .ready    (bus.mem_ready),
        .expired  (expired)
    );
    assign br_ret           = state_q == EXECUTE && !mem_op && bus.branch;
    assign st_ret           = state_q == MEM && bus.mem_ready && !bus.mem_read;
    assign bus.mem_req      = state_q == FETCH || state_q == MEM;
    assign bus.mem_we       = state_q == MEM && bus.mem_write;
    assign bus.mem_addr_sel = state_q == MEM;
    assign bus.ir_we        = state_q == FETCH && bus.mem_ready;
    assign bus.retired      = br_ret || st_ret || state_q == WB;
    assign bus.pc_we        = bus.retired;
    assign bus.pc_sel       = (br_ret && bus.branch_taken) ? PC_BRANCH :
                              (state_q == WB && bus.jump) ? PC_JUMP : PC_PLUS4;
    assign bus.rf_we        = state_q == WB && bus.reg_write;
    assign bus.trap         = trap_q;
    assign bus.trap_cause   = cause_q;
    assign bus.state_o      = state_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed latency table, hand-written trap/reset sequences and a random trace check.
module tb_multicycle_sequencer;
    import rv32_pkg::*;
    localparam int TO = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    multicycle_sequencer_if bus();
    multicycle_sequencer #(.MEM_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int total = 0;
    int bad = 0;

    typedef struct {
        logic run, clr, rw, mr, mw, br, jp, il, bt, rdy;
        logic [14:0] exp;
    } cyc_t;
    typedef struct {
        int kind, rw, bt, flat, dlat, drop;
        int lat, rf, psel, nxt, dwe;
    } dir_t;

    cyc_t tq[$];
    logic g_rw, g_mr, g_mw, g_br, g_jp, g_il, g_bt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {bus.state_o, bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we,
                bus.pc_sel, bus.rf_we, bus.retired, bus.trap, bus.trap_cause};
    endfunction

    function automatic logic [14:0] mk(int st, bit req, bit we, bit asel, bit irwe, bit pcwe,
                                       int psel, bit rfwe, bit ret, bit trp, int cause);
        return {3'(st), req, we, asel, irwe, pcwe, 2'(psel), rfwe, ret, trp, 2'(cause)};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic set_dec(input logic rw, mr, mw, br, jp, il, bt);
        bus.reg_write = rw; bus.mem_read = mr; bus.mem_write = mw; bus.branch = br;
        bus.jump = jp; bus.illegal = il; bus.branch_taken = bt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.run = 0; bus.clear_trap = 0; bus.mem_ready = 0;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", 32'(outs()), 32'h0);
        rst_n = 1'b1;
    endtask

    // trace generation: expected per-cycle behaviour built from instruction class and memory latency
    task automatic push(input logic run, input logic clr, input logic rdy, input logic [14:0] e);
        cyc_t c;
        c.run = run; c.clr = clr; c.rdy = rdy; c.exp = e;
        c.rw = g_rw; c.mr = g_mr; c.mw = g_mw; c.br = g_br; c.jp = g_jp; c.il = g_il; c.bt = g_bt;
        tq.push_back(c);
    endtask

    task automatic push_idle();
        push(1'b1, rb(), rb(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic push_trap(input int cause);
        int hold = $urandom_range(0, 2);
        push(rb(), 1'b0, rb(), mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 1, cause));
        for (int i = 0; i < hold; i++) push(rb(), 1'b0, rb(), mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, cause));
        push(rb(), 1'b1, rb(), mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, cause));
        push_idle();
    endtask

    // kind: 0 alu, 1 jump, 2 branch, 3 load, 4 store, 5 illegal
    task automatic gen_instr(input int kind, input int flat, input int dlat, input bit drop);
        bit last, done;
        g_rw = (kind == 3) || (kind < 2 && rb()); g_mr = kind == 3; g_mw = kind == 4;
        g_br = kind == 2; g_jp = kind == 1; g_il = kind == 5; g_bt = rb();
        for (int k = 1; k <= (flat > TO ? TO : flat); k++)
            push(rb(), rb(), k == flat, mk(1, 1, 0, 0, k == flat, 0, 0, 0, 0, 0, 0));
        if (flat > TO) begin push_trap(2); return; end
        push(rb(), rb(), rb(), mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (kind == 5) begin push_trap(1); return; end
        if (kind == 2) begin
            push(!drop, rb(), rb(), mk(3, 0, 0, 0, 0, 1, g_bt, 0, 1, 0, 0));
            if (drop) push_idle();
            return;
        end
        push(rb(), rb(), rb(), mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (kind >= 3) begin
            for (int k = 1; k <= (dlat > TO ? TO : dlat); k++) begin
                last = k == dlat;
                done = last && kind == 4;
                push(done ? !drop : rb(), rb(), last, mk(4, 1, g_mw, 1, 0, done, 0, 0, done, 0, 0));
            end
            if (dlat > TO) begin push_trap(3); return; end
            if (kind == 4) begin
                if (drop) push_idle();
                return;
            end
        end
        push(!drop, rb(), rb(), mk(5, 0, 0, 0, 0, 1, g_jp ? 2 : 0, g_rw, 1, 0, 0));
        if (drop) push_idle();
    endtask

    // directed: a reactive memory answers in the requested cycle; measure latency and retire strobes
    task automatic run_dir(input dir_t d, input int idx);
        int k = 0, rc = 0, lat = -1;
        logic prev_sel = 1'b0, we_seen = 1'b0, rf = 1'b0;
        logic [1:0] ps = 2'b00;
        set_dec(1'(d.rw), d.kind == 3, d.kind == 4, d.kind == 2, d.kind == 1, 1'b0, 1'(d.bt));
        bus.run = 1'b1;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            if (k > 0 || bus.state_o == FETCH) k++;
            rc = bus.mem_req ? ((rc > 0 && bus.mem_addr_sel == prev_sel) ? rc + 1 : 1) : 0;
            prev_sel = bus.mem_addr_sel;
            bus.mem_ready = bus.mem_req && rc == (bus.mem_addr_sel ? d.dlat : d.flat);
            #1;
            if (bus.mem_req && bus.mem_addr_sel && bus.mem_we) we_seen = 1'b1;
            if (bus.retired) begin
                lat = k; rf = bus.rf_we; ps = bus.pc_sel;
                bus.run = !d.drop;
            end
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b0;
        check($sformatf("dir%0d_latency", idx), 32'(lat), 32'(d.lat));
        check($sformatf("dir%0d_rf_we", idx), 32'(rf), 32'(d.rf));
        check($sformatf("dir%0d_pc_sel", idx), 32'(ps), 32'(d.psel));
        check($sformatf("dir%0d_mem_we", idx), 32'(we_seen), 32'(d.dwe));
        check($sformatf("dir%0d_next_state", idx), 32'(bus.state_o), 32'(d.nxt));
    endtask

    initial begin
        dir_t dt[9];
        int reqs, traps;
        dt[0] = '{0, 1, 0, 1, 1, 0, 4, 1, 0, 1, 0};
        dt[1] = '{3, 1, 0, 1, 4, 0, 8, 1, 0, 1, 0};
        dt[2] = '{2, 0, 1, 1, 1, 0, 3, 0, 1, 1, 0};
        dt[3] = '{2, 0, 0, 1, 1, 0, 3, 0, 0, 1, 0};
        dt[4] = '{1, 1, 0, 1, 1, 0, 4, 1, 2, 1, 0};
        dt[5] = '{4, 0, 0, 1, 1, 1, 4, 0, 0, 0, 1};
        dt[6] = '{0, 0, 0, 4, 1, 0, 7, 0, 0, 1, 0};
        dt[7] = '{3, 1, 1, 2, 1, 1, 6, 1, 0, 0, 0};
        dt[8] = '{4, 0, 1, 1, 4, 0, 7, 0, 0, 1, 1};
        do_reset();
        @(posedge clk); #1;
        foreach (dt[i]) run_dir(dt[i], i);

        // fetch timeout: request held exactly TO cycles, single trap pulse, clear back to idle
        do_reset();
        @(posedge clk); #1;
        set_dec(0, 0, 0, 0, 0, 0, 0);
        bus.run = 1'b1; bus.mem_ready = 1'b0;
        reqs = 0; traps = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            reqs += int'(bus.mem_req);
            traps += int'(bus.trap);
            @(posedge clk); #1;
        end
        check("to_req_cycles", 32'(reqs), 32'(TO));
        check("to_trap_pulses", 32'(traps), 32'd1);
        check("to_cause", 32'(bus.trap_cause), 32'(TRAP_IFETCH_TO));
        check("to_state", 32'(bus.state_o), 32'(TRAP));
        bus.run = 1'b0; bus.clear_trap = 1'b1;
        @(posedge clk); #1;
        bus.clear_trap = 1'b0;
        check("clear_state", 32'(bus.state_o), 32'(IDLE));
        check("clear_cause", 32'(bus.trap_cause), 32'(TRAP_NONE));

        // asynchronous reset mid-fetch drops the request without waiting for a clock
        bus.run = 1'b1;
        @(posedge clk); #1;
        check("fetch_req", 32'(bus.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", 32'(bus.mem_req), 32'd0);
        check("async_state", 32'(bus.state_o), 32'(IDLE));
        @(posedge clk); #1 rst_n = 1'b1;

        // random instruction trace against the expected cycle sequence
        do_reset();
        g_rw = 0; g_mr = 0; g_mw = 0; g_br = 0; g_jp = 0; g_il = 0; g_bt = 0;
        push_idle();
        for (int n = 0; n < 150; n++)
            gen_instr($urandom_range(0, 5),
                      $urandom_range(0, 9) == 0 ? TO + 1 : $urandom_range(1, TO),
                      $urandom_range(0, 9) == 0 ? TO + 1 : $urandom_range(1, TO),
                      $urandom_range(0, 4) == 0);
        foreach (tq[i]) begin
            @(posedge clk); #1;
            bus.run = tq[i].run; bus.clear_trap = tq[i].clr; bus.mem_ready = tq[i].rdy;
            set_dec(tq[i].rw, tq[i].mr, tq[i].mw, tq[i].br, tq[i].jp, tq[i].il, tq[i].bt);
            #2 check($sformatf("trace%0d", i), 32'(outs()), 32'(tq[i].exp));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
